// File: rtl/v_mux3_pkg.sv
// Shared encodings and the round-robin winner function for the 3:1 mux arbiter.
package v_mux3_pkg;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Search ptr+1, ptr+2, ptr (mod 3); the nearest requester after ptr wins.
  // Returns SEL_NONE when nothing is requesting.
  function automatic logic [1:0] next_rr(input logic [1:0] ptr, input logic [2:0] req);
    int idx;
    next_rr = SEL_NONE;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(ptr) + k) % 3;
      if (req[idx]) next_rr = 2'(idx);
    end
  endfunction

endpackage

// File: rtl/v_mux3_sel.sv
// Combinational 3:1 data mux; the unused select code yields zero.
module v_mux3_sel
  import v_mux3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic [WIDTH-1:0] dc,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = da;
      SEL_B:   y = db;
      SEL_C:   y = dc;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/v_mux3_rr_arbiter.sv
// Round-robin arbiter with per-grant hold limit driving a registered 3:1 mux.
module v_mux3_rr_arbiter
  import v_mux3_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [2:0]       REQ,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  input  logic [WIDTH-1:0] DC,
  output logic [2:0]       GNT,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] O,
  output logic             O_VLD,
  output state_t           dbg_state
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      ptr;
  logic [1:0]      winner;
  logic [3:0]      req_pad;
  logic            release_g;
  logic [WIDTH-1:0] mux_y;

  // While BUSY, ptr always equals the current grantee.
  assign req_pad   = {1'b0, REQ};
  assign winner    = next_rr(ptr, REQ);
  assign release_g = !req_pad[ptr] || (cnt == CNT_MAX);
  assign dbg_state = state;

  v_mux3_sel #(.WIDTH(WIDTH)) u_sel (
    .sel (S),
    .da  (DA),
    .db  (DB),
    .dc  (DC),
    .y   (mux_y)
  );

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_IDLE;
      GNT   <= 3'b000;
      S     <= SEL_NONE;
      O     <= '0;
      O_VLD <= 1'b0;
      cnt   <= '0;
      ptr   <= SEL_C;
    end else begin
      if (GNT != 3'b000) O <= mux_y;
      O_VLD <= |GNT;
      case (state)
        ST_IDLE: begin
          if (|REQ) begin
            state <= ST_BUSY;
            GNT   <= 3'b001 << winner;
            S     <= winner;
            cnt   <= CNT_ONE;
            ptr   <= winner;
          end
        end
        ST_BUSY: begin
          if (release_g) begin
            // Re-arbitration covers both hand-over and lone re-grant of ptr.
            if (|REQ) begin
              GNT <= 3'b001 << winner;
              S   <= winner;
              cnt <= CNT_ONE;
              ptr <= winner;
            end else begin
              state <= ST_IDLE;
              GNT   <= 3'b000;
              S     <= SEL_NONE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          GNT   <= 3'b000;
          S     <= SEL_NONE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_mux3_rr_arbiter.sv
// Self-checking bench for v_mux3_rr_arbiter against a queue-free owner/hold model.
module tb_v_mux3_rr_arbiter;
  import v_mux3_pkg::*;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             C;
  logic             CLR_N;
  logic [2:0]       REQ;
  logic [WIDTH-1:0] DA, DB, DC;
  logic [2:0]       GNT;
  logic [1:0]       S;
  logic [WIDTH-1:0] O;
  logic             O_VLD;
  state_t           dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the path, for how long, and who was served last.
  int               m_owner;
  int               m_hold;
  int               m_last;
  logic [WIDTH-1:0] m_o;
  logic             m_vld;

  v_mux3_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .C         (C),
    .CLR_N     (CLR_N),
    .REQ       (REQ),
    .DA        (DA),
    .DB        (DB),
    .DC        (DC),
    .GNT       (GNT),
    .S         (S),
    .O         (O),
    .O_VLD     (O_VLD),
    .dbg_state (dbg_state)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic logic [WIDTH-1:0] data_of(input int idx);
    case (idx)
      0:       return DA;
      1:       return DB;
      default: return DC;
    endcase
  endfunction

  function automatic logic [2:0] exp_gnt();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  function automatic logic [1:0] exp_sel();
    return (m_owner < 0) ? 2'b11 : 2'(m_owner);
  endfunction

  function automatic state_t exp_state();
    return (m_owner < 0) ? ST_IDLE : ST_BUSY;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 2;
    m_o     = '0;
    m_vld   = 1'b0;
  endtask

  // Advance the model with the inputs present this cycle, then cross one edge.
  task automatic step();
    int  w;
    int  idx;
    bit  rel;
    if (m_owner >= 0) m_o = data_of(m_owner);
    m_vld = (m_owner >= 0);
    rel = (m_owner < 0) || !REQ[m_owner] || (m_hold == MAX_HOLD);
    if (rel) begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (w < 0 && REQ[idx]) w = idx;
      end
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
        m_last  = w;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else begin
      m_hold++;
    end
    @(posedge C);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge C);
    CLR_N = 1'b0;
    REQ   = 3'b000;
    model_reset();
    @(negedge C);
    CLR_N = 1'b1;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    REQ   = 3'b111;
    DA = 8'h11; DB = 8'h22; DC = 8'h33;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge C);
      #1;
      total++;
      if ({GNT, S, O, O_VLD} !== {3'b000, 2'b11, 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b s=%b o=%h vld=%b exp 000/11/00/0", i, GNT, S, O, O_VLD);
      end
      total++;
      if (dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
      end
    end
    @(negedge C);
    REQ   = 3'b000;
    CLR_N = 1'b1;
  endtask

  task automatic test_single();
    logic [2:0]       g_exp[5] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    logic [1:0]       s_exp[5] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    logic             v_exp[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] o_exp[5] = '{8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    apply_reset();
    DA = 8'hA1; DC = 8'hC1; DB = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      REQ = (i < 3) ? 3'b010 : 3'b000;
      step();
      total++;
      if ({GNT, S, O, O_VLD} !== {g_exp[i], s_exp[i], o_exp[i], v_exp[i]}) begin
        bad++;
        $display("FAIL single_b cyc=%0d got gnt=%b s=%b o=%h vld=%b exp %b/%b/%h/%b",
                 i, GNT, S, O, O_VLD, g_exp[i], s_exp[i], o_exp[i], v_exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [2:0] g;
    apply_reset();
    REQ = 3'b111;
    for (int i = 0; i < 14; i++) begin
      DA = 8'($urandom); DB = 8'($urandom); DC = 8'($urandom);
      step();
      g = 3'(1 << ((i / MAX_HOLD) % 3));
      total++;
      if (GNT !== g) begin
        bad++;
        $display("FAIL contention_gnt cyc=%0d got=%b exp=%b", i, GNT, g);
      end
      total++;
      if ({O, O_VLD} !== {m_o, m_vld}) begin
        bad++;
        $display("FAIL contention_data cyc=%0d got o=%h vld=%b exp o=%h vld=%b", i, O, O_VLD, m_o, m_vld);
      end
    end
  endtask

  task automatic test_hold_limit();
    apply_reset();
    REQ = 3'b100;
    for (int i = 0; i < 10; i++) begin
      DC = 8'($urandom);
      step();
      total++;
      if ({GNT, S, dbg_state} !== {3'b100, 2'b10, ST_BUSY}) begin
        bad++;
        $display("FAIL hold_gnt cyc=%0d got gnt=%b s=%b st=%0d exp 100/10/busy", i, GNT, S, dbg_state);
      end
      total++;
      if (O_VLD !== (i > 0) || O !== m_o) begin
        bad++;
        $display("FAIL hold_data cyc=%0d got o=%h vld=%b exp o=%h vld=%b", i, O, O_VLD, m_o, (i > 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    REQ = 3'b001; DA = 8'h11; DB = 8'hB0; DC = 8'hC0;
    step();
    total++;
    if (GNT !== 3'b001) begin
      bad++;
      $display("FAIL early_first got=%b exp=001", GNT);
    end
    REQ = 3'b110; DA = 8'h22; DB = 8'h33;
    step();
    total++;
    if ({GNT, S, O, O_VLD} !== {3'b010, 2'b01, 8'h22, 1'b1}) begin
      bad++;
      $display("FAIL early_handover got gnt=%b s=%b o=%h vld=%b exp 010/01/22/1", GNT, S, O, O_VLD);
    end
    DB = 8'h44;
    step();
    total++;
    if ({GNT, O, O_VLD} !== {3'b010, 8'h44, 1'b1}) begin
      bad++;
      $display("FAIL early_nobubble got gnt=%b o=%h vld=%b exp 010/44/1", GNT, O, O_VLD);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    REQ = 3'b010; DB = 8'hC3;
    step();
    step();
    total++;
    if ({GNT, O} !== {3'b010, 8'hC3}) begin
      bad++;
      $display("FAIL midrst_pre got gnt=%b o=%h exp 010/c3", GNT, O);
    end
    #2;
    CLR_N = 1'b0;
    #1;
    total++;
    if ({GNT, S, O, O_VLD, dbg_state} !== {3'b000, 2'b11, 8'h00, 1'b0, ST_IDLE}) begin
      bad++;
      $display("FAIL midrst_clear got gnt=%b s=%b o=%h vld=%b st=%0d exp 000/11/00/0/idle",
               GNT, S, O, O_VLD, dbg_state);
    end
    model_reset();
    @(negedge C);
    CLR_N = 1'b1;
    REQ = 3'b111;
    step();
    total++;
    if (GNT !== 3'b001) begin
      bad++;
      $display("FAIL midrst_first got=%b exp=001", GNT);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) REQ = 3'($urandom);
      DA = 8'($urandom); DB = 8'($urandom); DC = 8'($urandom);
      step();
      total++;
      if ({GNT, S, O, O_VLD, dbg_state} !== {exp_gnt(), exp_sel(), m_o, m_vld, exp_state()}) begin
        bad++;
        $display("FAIL random cyc=%0d got gnt=%b s=%b o=%h vld=%b st=%0d exp %b/%b/%h/%b/%0d",
                 i, GNT, S, O, O_VLD, dbg_state, exp_gnt(), exp_sel(), m_o, m_vld, exp_state());
      end
    end
  endtask

  initial begin
    CLR_N = 1'b0;
    REQ   = 3'b000;
    DA = '0; DB = '0; DC = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_hold_limit();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
